// File: rtl/gpio_wb_irq_if.sv
// Wishbone classic bus bundle for the gpio_wb_irq slave.
// Signal names are given from the slave's point of view.
interface gpio_wb_irq_if;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [31:0] adr_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        cyc_i;
    logic        stb_i;
    logic        ack_o;

    modport master (
        output dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/gpio_wb_irq.sv
// Wishbone GPIO peripheral: direction control, atomic set/clear of outputs,
// synchronised inputs and per-pin edge interrupts folded into one level irq.
module gpio_wb_irq #(
    parameter int unsigned GPIO_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gpio_wb_irq_if.slave      wb,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              irq_o
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_OUT_SET  = 3'd1;
    localparam logic [2:0] REG_OUT_CLR  = 3'd2;
    localparam logic [2:0] REG_DIR      = 3'd3;
    localparam logic [2:0] REG_IN       = 3'd4;
    localparam logic [2:0] REG_IRQ_EN   = 3'd5;
    localparam logic [2:0] REG_IRQ_EDGE = 3'd6;
    localparam logic [2:0] REG_IRQ_STAT = 3'd7;

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              irq_q, irq_d;
    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [GPIO_W-1:0] irq_en_q, irq_en_d;
    logic [GPIO_W-1:0] irq_edge_q, irq_edge_d;
    logic [GPIO_W-1:0] irq_stat_q, irq_stat_d;
    logic [GPIO_W-1:0] s1_q, s2_q, prev_q;

    logic              access_s, hit_s, wr_s, rd_s;
    logic [2:0]        reg_sel_s;
    logic [31:0]       lane_mask_s, rdata_s;
    logic [GPIO_W-1:0] wmask_s, wdata_s, edge_det_s;
    logic              unused_s;

    assign access_s    = (state_q == ST_IDLE) && wb.cyc_i && wb.stb_i;
    assign hit_s       = (wb.adr_i[31:5] == BASE_ADDR[31:5]);
    assign reg_sel_s   = wb.adr_i[4:2];
    assign wr_s        = access_s && hit_s && wb.we_i;
    assign rd_s        = access_s && hit_s && !wb.we_i;
    assign lane_mask_s = {{8{wb.sel_i[3]}}, {8{wb.sel_i[2]}}, {8{wb.sel_i[1]}}, {8{wb.sel_i[0]}}};
    assign wmask_s     = lane_mask_s[GPIO_W-1:0];
    assign wdata_s     = wb.dat_i[GPIO_W-1:0] & wmask_s;
    assign edge_det_s  = (irq_edge_q & s2_q & ~prev_q) | (~irq_edge_q & ~s2_q & prev_q);
    assign unused_s    = ^{wb.adr_i[1:0], wb.dat_i, lane_mask_s};

    // Read multiplexer; write-only and unmapped offsets read as zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (reg_sel_s)
            REG_OUT:      rdata_s = 32'(out_q);
            REG_DIR:      rdata_s = 32'(dir_q);
            REG_IN:       rdata_s = 32'(s2_q);
            REG_IRQ_EN:   rdata_s = 32'(irq_en_q);
            REG_IRQ_EDGE: rdata_s = 32'(irq_edge_q);
            REG_IRQ_STAT: rdata_s = 32'(irq_stat_q);
            default:      rdata_s = 32'h0000_0000;
        endcase
    end

    // Register next-state: byte-lane writes, set/clear, and W1C that loses to a fresh edge.
    always_comb begin
        out_d      = out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_edge_d = irq_edge_q;
        irq_stat_d = irq_stat_q | edge_det_s;
        irq_d      = |(irq_stat_q & irq_en_q);
        if (wr_s) begin
            case (reg_sel_s)
                REG_OUT:      out_d      = (out_q & ~wmask_s) | wdata_s;
                REG_OUT_SET:  out_d      = out_q | wdata_s;
                REG_OUT_CLR:  out_d      = out_q & ~wdata_s;
                REG_DIR:      dir_d      = (dir_q & ~wmask_s) | wdata_s;
                REG_IRQ_EN:   irq_en_d   = (irq_en_q & ~wmask_s) | wdata_s;
                REG_IRQ_EDGE: irq_edge_d = (irq_edge_q & ~wmask_s) | wdata_s;
                REG_IRQ_STAT: irq_stat_d = (irq_stat_q & ~wdata_s) | edge_det_s;
                default:      out_d      = out_q;
            endcase
        end else begin
            irq_stat_d = irq_stat_q | edge_det_s;
        end
    end

    // Bus FSM next-state and registered handshake outputs.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dat_d   = rd_s ? rdata_s : 32'h0000_0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, register file and input synchroniser.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0000_0000;
            irq_q      <= 1'b0;
            out_q      <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_edge_q <= '0;
            irq_stat_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
            out_q      <= out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_edge_q <= irq_edge_d;
            irq_stat_q <= irq_stat_d;
            s1_q       <= gpio_i;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
        end
    end

    assign wb.dat_o  = dat_q;
    assign wb.ack_o  = ack_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_gpio_wb_irq.sv
// Self-checking bench for gpio_wb_irq: directed scenarios plus randomised bus and
// pin traffic, all compared every cycle against a register-level reference model.
module tb_gpio_wb_irq;
    localparam int unsigned W     = 16;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam logic [31:0] WMASK = 32'hFFFF_FFFF >> (32 - W);

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] gpio_i = '0;
    logic [W-1:0] gpio_o;
    logic [W-1:0] gpio_oe_o;
    logic         irq_o;

    int n_checks = 0;
    int n_errors = 0;

    gpio_wb_irq_if wb ();

    gpio_wb_irq #(.GPIO_W(W), .BASE_ADDR(BASE)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb        (wb),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acknowledge.
    task automatic bus_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        int n;
        n = 0;
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = we;
        wb.adr_i = a;
        wb.dat_i = d;
        wb.sel_i = s;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (wb.ack_o !== 1'b1 && n < 8);
        check("ack_seen", {31'h0, wb.ack_o}, 32'h1);
        rd = wb.dat_o;
        @(negedge clk_i);
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus_xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
        bus_xfer(1'b0, a, 32'h0, 4'hF, rd);
    endtask

    // Reference model: register contents by name, pin history as a sample pipeline.
    initial begin
        logic [31:0] m_out, m_dir, m_en, m_edge, m_stat, m_dat;
        logic [31:0] h0, h1, h2, mask, d, clr, edges;
        logic        m_ack, m_rd, m_irq, irq_next;
        {m_out, m_dir, m_en, m_edge, m_stat, m_dat, h0, h1, h2} = '0;
        {m_ack, m_rd, m_irq} = '0;
        forever begin
            @(posedge clk_i);
            if (rst_i) begin
                {m_out, m_dir, m_en, m_edge, m_stat, m_dat, h0, h1, h2} = '0;
                {m_ack, m_rd, m_irq} = '0;
            end else begin
                edges    = (m_edge & h1 & ~h2) | (~m_edge & ~h1 & h2);
                irq_next = |(m_stat & m_en);
                clr      = 32'h0;
                m_rd     = 1'b0;
                if (wb.cyc_i && wb.stb_i && !m_ack) begin
                    m_ack = 1'b1;
                    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{wb.sel_i[b]}};
                    mask = mask & WMASK;
                    d    = wb.dat_i & mask;
                    m_dat = 32'h0;
                    if (wb.adr_i[31:5] == BASE[31:5]) begin
                        if (wb.we_i) begin
                            case (wb.adr_i[4:2])
                                3'd0: m_out  = (m_out & ~mask) | d;
                                3'd1: m_out  = m_out | d;
                                3'd2: m_out  = m_out & ~d;
                                3'd3: m_dir  = (m_dir & ~mask) | d;
                                3'd5: m_en   = (m_en & ~mask) | d;
                                3'd6: m_edge = (m_edge & ~mask) | d;
                                3'd7: clr    = d;
                                default: ;
                            endcase
                        end else begin
                            m_rd = 1'b1;
                            case (wb.adr_i[4:2])
                                3'd0: m_dat = m_out;
                                3'd3: m_dat = m_dir;
                                3'd4: m_dat = h1;
                                3'd5: m_dat = m_en;
                                3'd6: m_dat = m_edge;
                                3'd7: m_dat = m_stat;
                                default: m_dat = 32'h0;
                            endcase
                        end
                    end else begin
                        m_rd = !wb.we_i;
                    end
                end else begin
                    m_ack = 1'b0;
                end
                m_stat = (m_stat & ~clr) | edges;
                m_irq  = irq_next;
                h2 = h1;
                h1 = h0;
                h0 = 32'(gpio_i);
            end
            #1;
            check("model_ack", {31'h0, wb.ack_o}, {31'h0, m_ack});
            if (m_ack && m_rd) check("model_dat", wb.dat_o, m_dat);
            check("model_gpio_o", 32'(gpio_o), m_out);
            check("model_gpio_oe", 32'(gpio_oe_o), m_dir);
            check("model_irq", {31'h0, irq_o}, {31'h0, m_irq});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
        wb.adr_i = 32'h0;
        wb.dat_i = 32'h0;
        wb.sel_i = 4'h0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe_o), 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(BASE + 32'(i) * 32'd4, rd);
            check("rst_read", rd, 32'h0);
        end

        bus_write(BASE + 32'h00, 32'h0000_005A, 4'hF);
        check("out_write", 32'(gpio_o), 32'h0000_005A);
        bus_write(BASE + 32'h04, 32'h0000_0081, 4'hF);
        check("out_set", 32'(gpio_o), 32'h0000_00DB);
        bus_write(BASE + 32'h08, 32'h0000_0018, 4'hF);
        check("out_clr", 32'(gpio_o), 32'h0000_00C3);
        bus_read(BASE + 32'h00, rd);
        check("out_read", rd, 32'h0000_00C3);
        bus_read(BASE + 32'h04, rd);
        check("set_reads_0", rd, 32'h0);

        bus_write(BASE + 32'h0C, 32'hFFFF_FFFF, 4'b0010);
        check("dir_lane1", 32'(gpio_oe_o), 32'h0000_FF00);
        bus_read(BASE + 32'h0C, rd);
        check("dir_read", rd, 32'h0000_FF00);
        bus_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
        check("miss_no_change", 32'(gpio_o), 32'h0000_00C3);
        bus_read(BASE + 32'h40, rd);
        check("miss_reads_0", rd, 32'h0);
        bus_write(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'h00, rd);
        check("upper_bits_0", rd, 32'h0000_FFFF);
        bus_write(BASE + 32'h0C, 32'h0, 4'hF);

        bus_write(BASE + 32'h18, 32'h1, 4'hF);
        bus_write(BASE + 32'h14, 32'h3, 4'hF);
        gpio_i[1:0] = 2'b11;
        repeat (3) @(posedge clk_i);
        #1 check("irq_k2", {31'h0, irq_o}, 32'h0);
        @(posedge clk_i);
        #1 check("irq_k3", {31'h0, irq_o}, 32'h1);
        @(negedge clk_i);
        bus_read(BASE + 32'h1C, rd);
        check("stat_rise", rd, 32'h1);
        gpio_i[1] = 1'b0;
        repeat (4) @(negedge clk_i);
        bus_read(BASE + 32'h1C, rd);
        check("stat_fall", rd, 32'h3);
        bus_write(BASE + 32'h1C, 32'h3, 4'hF);
        @(posedge clk_i);
        #1 check("irq_w1c", {31'h0, irq_o}, 32'h0);
        @(negedge clk_i);

        gpio_i[0] = 1'b0;
        repeat (4) @(negedge clk_i);
        gpio_i[0] = 1'b1;
        repeat (4) @(negedge clk_i);
        check("irq_pin0", {31'h0, irq_o}, 32'h1);
        gpio_i[0] = 1'b0;
        repeat (4) @(negedge clk_i);
        gpio_i[0] = 1'b1;
        repeat (2) @(negedge clk_i);
        bus_write(BASE + 32'h1C, 32'h1, 4'hF);
        check("race_irq_a", {31'h0, irq_o}, 32'h1);
        @(posedge clk_i);
        #1 check("race_irq_b", {31'h0, irq_o}, 32'h1);
        @(negedge clk_i);
        bus_read(BASE + 32'h1C, rd);
        check("race_stat", rd, 32'h1);
        bus_write(BASE + 32'h1C, 32'h1, 4'hF);
        @(negedge clk_i);

        bus_write(BASE + 32'h00, 32'h0000_00FF, 4'hF);
        gpio_i[1] = 1'b1;
        repeat (4) @(negedge clk_i);
        gpio_i[1] = 1'b0;
        repeat (4) @(negedge clk_i);
        check("pre_rst_irq", {31'h0, irq_o}, 32'h1);
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = 1'b0;
        wb.adr_i = BASE;
        @(posedge clk_i);
        #1 check("pre_rst_ack", {31'h0, wb.ack_o}, 32'h1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_ack", {31'h0, wb.ack_o}, 32'h0);
        check("rst_gpio", 32'(gpio_o), 32'h0);
        check("rst_irq_mid", {31'h0, irq_o}, 32'h0);
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        bus_read(BASE, rd);
        check("post_rst_read", rd, 32'h0);

        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) gpio_i = W'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk_i);
            end else begin
                a = BASE + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_1000;
                bus_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd);
            end
        end
        repeat (4) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/gpio_wb_irq.md
# gpio_wb_irq

Parametrised Wishbone-slave GPIO peripheral with per-pin direction control, atomic set/clear output registers, a synchronised input register, and per-pin edge-triggered interrupts. It sits on the system Wishbone bus next to the other memory-mapped peripherals and drives a pad ring or board-level pins. It supersedes the fixed 8-bit output-only GPIO and adds read-back, inputs, byte-lane writes and a level interrupt to the CPU.

## Interface
- GPIO_W, 8: number of pins, 1..32; register bits at and above GPIO_W read 0 and ignore writes.
- BASE_ADDR, 32'h00000400: byte base address, 32-byte aligned.
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- dat_i  in  32  Wishbone write data
- dat_o  out  32  Wishbone read data, registered
- adr_i  in  32  Wishbone byte address
- we_i  in  1  write enable
- sel_i  in  4  byte-lane selects, sel_i[n] gates dat_i[8n+7:8n] on writes
- cyc_i  in  1  bus cycle
- stb_i  in  1  strobe
- ack_o  out  1  transfer acknowledge, registered
- gpio_i  in  GPIO_W  asynchronous pin inputs
- gpio_o  out  GPIO_W  output values (= OUT register)
- gpio_oe_o  out  GPIO_W  output enables (= DIR register, 1 = drive)
- irq_o  out  1  level interrupt, registered

## Operation
- Decode: hit when adr_i[31:5] == BASE_ADDR[31:5]; register select is adr_i[4:2]; adr_i[1:0] ignored.
- Register map (offset, access):
  - 0x00 OUT, RW.
  - 0x04 OUT_SET, W: OUT |= data; reads 0.
  - 0x08 OUT_CLR, W: OUT &= ~data; reads 0.
  - 0x0C DIR, RW.
  - 0x10 IN, RO: synchronised pin values; writes ignored.
  - 0x14 IRQ_EN, RW.
  - 0x18 IRQ_EDGE, RW: 1 = rising edge, 0 = falling edge.
  - 0x1C IRQ_STAT, R/W1C.
- Byte lanes: every write applies only to the bytes selected by sel_i. For SET, CLR and W1C, unselected bytes have no effect.
- Bus FSM states:
  - IDLE: when cyc_i & stb_i, perform the access, capture dat_o, and go to ACK with ack_o = 1 on the same edge.
  - ACK: ack_o = 0, return to IDLE.
  - Result: exactly one one-cycle ack per access, minimum 2 cycles per access.
- Non-hit address: ack still given, dat_o = 0, no state change.
- Input path: 2-FF synchroniser (s1, s2) plus a prev register of s2. IN = s2.
- Edge detect: rise = s2 & ~prev, fall = ~s2 & prev. The edge for a pin is IRQ_EDGE ? rise : fall.
- Status: IRQ_STAT bit sets on a detected edge regardless of IRQ_EN. irq_o <= |(IRQ_STAT & IRQ_EN).
- Simultaneous events:
  - W1C and a new edge on the same bit in the same cycle: the bit stays set.
  - SET/CLR touch only OUT, so there is no conflict with the input path.
- Reset values: OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STAT, s1, s2, prev, dat_o, ack_o and irq_o are all 0; FSM in IDLE. gpio_o = 0 and gpio_oe_o = 0, so all pins are tri-stated.
- Reset asserted mid-transaction: ack_o drops immediately, and the master must restart the cycle.

## Timing
- Write takes effect at the same edge ack_o rises. gpio_o and gpio_oe_o update that edge.
- Read data is valid in dat_o while ack_o = 1.
- gpio_i latency (gpio_i stable before edge k):
  - s1 at k, s2/IN at k+1.
  - IRQ_STAT set at k+2.
  - irq_o at k+3, if the bit is enabled.
- Pulses shorter than one clock may be missed; this is acceptable.
- Enabling IRQ_EN on an already-set status bit raises irq_o one cycle after the write's ack edge.
- After W1C of the last pending enabled bit, irq_o falls one cycle after the ack edge.

## Test plan
- Reset, then read all 8 offsets -> all read 0. gpio_o = 0, gpio_oe_o = 0, irq_o = 0. Each read gets exactly one 1-cycle ack.
- GPIO_W = 8: write OUT = 0x5A, then OUT_SET = 0x81, then OUT_CLR = 0x18 -> gpio_o goes 0x5A, 0xDB, 0xC3. Reading OUT returns 0xC3; reading OUT_SET returns 0.
- GPIO_W = 32: write DIR = 0xFFFFFFFF with sel_i = 4'b0010 -> DIR = 0x0000FF00. An access at BASE+0x40 is acked, reads 0, and changes nothing.
- IRQ_EDGE = 0x01, IRQ_EN = 0x03:
  - Raise gpio_i[0] and gpio_i[1] at edge k -> IRQ_STAT = 0x01 at k+2, irq_o = 1 at k+3.
  - Drop gpio_i[1] -> IRQ_STAT = 0x03.
  - W1C 0x03 -> irq_o = 0.
- Time a W1C of bit 0 to land in the same cycle as a new rising edge on pin 0 -> IRQ_STAT[0] stays 1 and irq_o stays 1.
- Assert rst_i during the ACK state with OUT = 0xFF -> ack_o, gpio_o and irq_o are 0 immediately. A fresh read after reset completes normally.
